// File: rtl/mem_load_store_unit.sv
// rtl/mem_load_store_unit.sv - byte/half/word load-store unit over a word-addressed data memory
// Optional LSU_STATS_EN adds stat_loads/stat_stores/stat_errors counters.
module mem_load_store_unit #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef LSU_STATS_EN
  ,
  output logic [31:0]       stat_loads,
  output logic [31:0]       stat_stores,
  output logic [31:0]       stat_errors
`endif
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] WRITE  = 3'd2;
  localparam logic [2:0] RMW_RD = 3'd3;
  localparam logic [2:0] RMW_WR = 3'd4;
  localparam logic [2:0] RESP   = 3'd5;

  logic [2:0]  state;
  logic [1:0]  opSize;
  logic [1:0]  opLane;
  logic        opUnsigned;
  logic [31:0] opWdata;
  logic        reqErr;

  function automatic logic [31:0] extractLoad(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic isUnsigned);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] result;
    b = word[8*lane +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'd0:    result = {{24{b[7] & ~isUnsigned}}, b};
      2'd1:    result = {{16{h[15] & ~isUnsigned}}, h};
      default: result = word;
    endcase
    return result;
  endfunction

  function automatic logic [31:0] mergeStore(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [1:0] size, input logic [31:0] data);
    logic [31:0] result;
    result = word;
    if (size == 2'd0) result[8*lane +: 8] = data[7:0];
    else if (lane[1]) result[31:16] = data[15:0];
    else              result[15:0]  = data[15:0];
    return result;
  endfunction

  assign reqErr = (req_size == 2'd3) ||
                  (req_size == 2'd2 && req_addr[1:0] != 2'd0) ||
                  (req_size == 2'd1 && req_addr[0]) ||
                  (req_addr[31:ADDR_W+2] != '0);

  assign req_ready = (state == IDLE);

  // All memory-side outputs are registered so they hold steady for the whole cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      opSize     <= 2'd0;
      opLane     <= 2'd0;
      opUnsigned <= 1'b0;
      opWdata    <= 32'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_wdata  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            opSize     <= req_size;
            opLane     <= req_addr[1:0];
            opUnsigned <= req_unsigned;
            opWdata    <= req_wdata;
            if (reqErr) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else begin
              mem_addr <= req_addr[ADDR_W+1:2];
              if (!req_we) begin
                state  <= LOAD;
                mem_re <= 1'b1;
              end else if (req_size == 2'd2) begin
                state     <= WRITE;
                mem_we    <= 1'b1;
                mem_wdata <= req_wdata;
              end else begin
                state  <= RMW_RD;
                mem_re <= 1'b1;
              end
            end
          end
        end
        LOAD: begin
          mem_re     <= 1'b0;
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= extractLoad(mem_rdata, opLane, opSize, opUnsigned);
        end
        RMW_RD: begin
          mem_re    <= 1'b0;
          mem_we    <= 1'b1;
          mem_wdata <= mergeStore(mem_rdata, opLane, opSize, opWdata);
          state     <= RMW_WR;
        end
        WRITE, RMW_WR: begin
          mem_we     <= 1'b0;
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
        end
        RESP: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LSU_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_loads  <= 32'd0;
      stat_stores <= 32'd0;
      stat_errors <= 32'd0;
    end else begin
      if (state == LOAD) stat_loads <= stat_loads + 32'd1;
      if (state == WRITE || state == RMW_WR) stat_stores <= stat_stores + 32'd1;
      if (state == IDLE && req_valid && reqErr) stat_errors <= stat_errors + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_load_store_unit.sv
// tb/tb_mem_load_store_unit.sv - randomized self-checking bench for mem_load_store_unit
// Define LSU_STATS_EN to also check the statistics counters.
module tb_mem_load_store_unit;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
`ifdef LSU_STATS_EN
  logic [31:0]       stat_loads, stat_stores, stat_errors;
  int                refLoads = 0, refStores = 0, refErrors = 0;
`endif

  logic [31:0] tbMem  [DEPTH];
  logic [31:0] refMem [DEPTH];
  int testCount = 0;
  int failCount = 0;

  mem_load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef LSU_STATS_EN
    , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errors(stat_errors)
`endif
  );

  always #5 clk = ~clk;

  assign mem_rdata = tbMem[mem_addr];
  always @(posedge clk) if (mem_we) tbMem[mem_addr] <= mem_wdata;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic doReq(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bit          expErr;
    int          expLat, lat, reCnt, weCnt, waitCnt, idx;
    bit          addrBad, overlap;
    logic [31:0] word, expRdata, mask, lane;
    expErr = (size == 2'd3) || (size == 2'd2 && addr[1:0] != 0) ||
             (size == 2'd1 && addr[0]) || ((addr >> (ADDR_W + 2)) != 0);
    idx  = int'((addr >> 2) % DEPTH);
    word = refMem[idx];
    expRdata = 32'd0;
    if (!expErr && !we) begin
      if (size == 2'd0) begin
        lane = (word >> (8 * addr[1:0])) & 32'hFF;
        if (!uns && lane >= 32'h80) lane = lane | 32'hFFFF_FF00;
        expRdata = lane;
      end else if (size == 2'd1) begin
        lane = (word >> (16 * addr[1])) & 32'hFFFF;
        if (!uns && lane >= 32'h8000) lane = lane | 32'hFFFF_0000;
        expRdata = lane;
      end else expRdata = word;
    end
    if (!expErr && we) begin
      if (size == 2'd2) refMem[idx] = wdata;
      else begin
        mask = (size == 2'd0) ? 32'hFF : 32'hFFFF;
        refMem[idx] = (word & ~(mask << (8 * addr[1:0]))) | ((wdata & mask) << (8 * addr[1:0]));
      end
    end
    expLat = expErr ? 0 : ((we && size != 2'd2) ? 2 : 1);
`ifdef LSU_STATS_EN
    if (expErr) refErrors++; else if (we) refStores++; else refLoads++;
`endif

    @(negedge clk);
    waitCnt = 0;
    while (!req_ready && waitCnt < 10) begin @(negedge clk); waitCnt++; end
    checkVal("ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = $urandom; req_size = 2'($urandom);
    req_unsigned = $urandom; req_addr = $urandom; req_wdata = $urandom;

    lat = -1; reCnt = 0; weCnt = 0; addrBad = 0; overlap = 0;
    for (int c = 0; c < 6 && lat < 0; c++) begin
      @(negedge clk);
      if (mem_re) begin reCnt++; if (int'(mem_addr) != idx) addrBad = 1; end
      if (mem_we) begin weCnt++; if (int'(mem_addr) != idx) addrBad = 1; end
      if (mem_re && mem_we) overlap = 1;
      if (resp_valid) lat = c;
    end
    checkVal("latency", 32'(lat), 32'(expLat));
    checkVal("resp_err", 32'(resp_err), 32'(expErr));
    checkVal("resp_rdata", resp_rdata, expRdata);
    checkVal("mem_re_cycles", 32'(reCnt), (!expErr && (!we || size != 2'd2)) ? 32'd1 : 32'd0);
    checkVal("mem_we_cycles", 32'(weCnt), (!expErr && we) ? 32'd1 : 32'd0);
    checkVal("mem_addr", 32'(addrBad), 32'd0);
    checkVal("re_we_overlap", 32'(overlap), 32'd0);
    @(negedge clk);
    checkVal("resp_one_cycle", 32'(resp_valid), 32'd0);
    checkVal("rdata_hold", resp_rdata, expRdata);
    checkVal("mem_word", tbMem[idx], refMem[idx]);
  endtask

  initial begin
    logic [1:0]  rs;
    logic [31:0] ra;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      tbMem[i] = $urandom; refMem[i] = tbMem[i];
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkVal("rst_ready", 32'(req_ready), 32'd1);
    checkVal("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkVal("rst_resp_err", 32'(resp_err), 32'd0);
    checkVal("rst_resp_rdata", resp_rdata, 32'd0);
    checkVal("rst_mem_re", 32'(mem_re), 32'd0);
    checkVal("rst_mem_we", 32'(mem_we), 32'd0);
    checkVal("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkVal("rst_mem_wdata", mem_wdata, 32'd0);

    tbMem[2] = 32'h8000_00F0; refMem[2] = 32'h8000_00F0;
    doReq(1'b0, 2'd2, 1'b0, 32'h08, 32'd0);
    checkVal("lw_const", resp_rdata, 32'h8000_00F0);
    tbMem[2] = 32'h80FF_0000; refMem[2] = 32'h80FF_0000;
    doReq(1'b0, 2'd0, 1'b0, 32'h0B, 32'd0);
    checkVal("lb_const", resp_rdata, 32'hFFFF_FF80);
    doReq(1'b0, 2'd0, 1'b1, 32'h0B, 32'd0);
    checkVal("lbu_const", resp_rdata, 32'h0000_0080);
    doReq(1'b0, 2'd1, 1'b1, 32'h0A, 32'd0);
    checkVal("lhu_const", resp_rdata, 32'h0000_80FF);
    tbMem[1] = 32'h1111_1111; refMem[1] = 32'h1111_1111;
    doReq(1'b1, 2'd0, 1'b0, 32'h05, 32'h1234_56AB);
    checkVal("sb_const", tbMem[1], 32'h1111_AB11);
    doReq(1'b0, 2'd2, 1'b0, 32'h06, 32'd0);
    doReq(1'b1, 2'd1, 1'b0, 32'h03, 32'h5555_5555);
    doReq(1'b0, 2'd2, 1'b0, 32'h200, 32'd0);
    doReq(1'b0, 2'd3, 1'b0, 32'h00, 32'd0);

    for (int n = 0; n < 250; n++) begin
      rs = 2'($urandom_range(0, 7) == 0 ? 3 : $urandom_range(0, 2));
      ra = ($urandom_range(0, 15) == 0) ? 32'($urandom) : 32'($urandom_range(0, 4 * DEPTH - 1));
      if (rs == 2'd2 && $urandom_range(0, 3) != 0) ra[1:0] = 2'd0;
      if (rs == 2'd1 && $urandom_range(0, 3) != 0) ra[0] = 1'b0;
      doReq(1'($urandom), rs, 1'($urandom), ra, $urandom);
    end

`ifdef LSU_STATS_EN
    checkVal("stat_loads", stat_loads, 32'(refLoads));
    checkVal("stat_stores", stat_stores, 32'(refStores));
    checkVal("stat_errors", stat_errors, 32'(refErrors));
`endif

    // Abort a word store with reset during its WRITE cycle.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h10; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checkVal("abort_we_before", 32'(mem_we), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    refMem[4] = 32'hDEAD_BEEF;
    @(negedge clk);
    checkVal("abort_mem_we", 32'(mem_we), 32'd0);
    checkVal("abort_ready", 32'(req_ready), 32'd1);
    checkVal("abort_resp_rdata", resp_rdata, 32'd0);
    for (int c = 0; c < 3; c++) begin
      checkVal("abort_no_resp", 32'(resp_valid), 32'd0);
      @(negedge clk);
    end
`ifdef LSU_STATS_EN
    checkVal("stat_loads_rst", stat_loads, 32'd0);
    checkVal("stat_stores_rst", stat_stores, 32'd0);
    checkVal("stat_errors_rst", stat_errors, 32'd0);
    refLoads = 0; refStores = 0; refErrors = 0;
`endif
    doReq(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    checkVal("post_abort_lw", resp_rdata, 32'hDEAD_BEEF);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
